// File: rtl/tinyalu_param.sv
`default_nettype none
// ============================================================================
//  Module   : tinyalu_param
//  Purpose  : Parametrised TinyALU core with start-held / done-pulse handshake,
//             multi-cycle multiply, error flag for the illegal opcode.
//  Revision : 1.0 - initial release
// ============================================================================
module tinyalu_param #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           op,
  input  logic                 start,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result
);

  localparam logic [2:0] c_op_nop = 3'b000;
  localparam logic [2:0] c_op_add = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_xor = 3'b011;
  localparam logic [2:0] c_op_mul = 3'b100;
  localparam logic [2:0] c_op_sub = 3'b101;
  localparam logic [2:0] c_op_or  = 3'b110;
  localparam logic [2:0] c_op_ill = 3'b111;

  localparam int                 c_cnt_w    = 3;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_MULWAIT = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2:0]           r_op;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_result;
  logic [2*WIDTH-1:0]   w_alu;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic                 w_capture;
  logic                 w_done;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (op != c_op_nop)) begin
          w_capture    = 1'b1;
          w_state_next = (op == c_op_mul) ? S_MULWAIT : S_EXEC;
        end
      end
      S_EXEC: begin
        w_done       = 1'b1;
        w_state_next = S_HOLD;
      end
      S_MULWAIT: begin
        if (r_cnt == '0) begin
          w_done       = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        // A held start must drop before another command can be accepted
        if (!start) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_a_ext = {{WIDTH{1'b0}}, r_a};
    w_b_ext = {{WIDTH{1'b0}}, r_b};
    w_alu   = '0;
    case (r_op)
      c_op_add: w_alu = w_a_ext + w_b_ext;
      c_op_and: w_alu = w_a_ext & w_b_ext;
      c_op_xor: w_alu = w_a_ext ^ w_b_ext;
      c_op_mul: w_alu = w_a_ext * w_b_ext;
      c_op_sub: w_alu = w_a_ext - w_b_ext;
      c_op_or:  w_alu = w_a_ext | w_b_ext;
      default:  w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= c_op_nop;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_a   <= A;
        r_b   <= B;
        r_op  <= op;
        r_cnt <= c_cnt_load;
      end else if ((r_state == S_MULWAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done) begin
        r_result <= w_alu;
      end
    end
  end

  // Result is presented live in the done cycle and held afterwards
  assign done   = w_done;
  assign err    = w_done && (r_op == c_op_ill);
  assign busy   = (r_state == S_EXEC) || (r_state == S_MULWAIT);
  assign result = w_done ? w_alu : r_result;

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tinyalu_param
//  Purpose  : Scoreboard bench for tinyalu_param (WIDTH=8, MUL_CYCLES=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tinyalu_param;

  localparam int WIDTH      = 8;
  localparam int MUL_CYCLES = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   A;
  logic [7:0]   B;
  logic [2:0]   op;
  logic         done;
  logic         err;
  logic         busy;
  logic [15:0]  result;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  sb_res[$];
  logic         sb_err[$];

  always #5 clk = ~clk;

  tinyalu_param #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .op     (op),
    .start  (start),
    .done   (done),
    .err    (err),
    .busy   (busy),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] xa;
    logic [15:0] xb;
    xa = {8'h00, a};
    xb = {8'h00, b};
    case (o)
      3'b001:  return xa + xb;
      3'b010:  return xa & xb;
      3'b011:  return xa ^ xb;
      3'b100:  return xa * xb;
      3'b101:  return xa - xb;
      3'b110:  return xa | xb;
      default: return 16'h0000;
    endcase
  endfunction

  // Issue one command, wait for done, compare against the scoreboard, then
  // keep start high for 'hold' extra cycles before releasing it.
  task automatic run_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input int lat, input int hold);
    int          n;
    logic [15:0] er;
    logic        ee;
    n = 0;
    sb_res.push_back(model(o, a, b));
    sb_err.push_back(o == 3'b111);
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      A  = ~a;
      B  = ~b;
      op = o ^ 3'b011;
      check("busy_exec", 32'(busy), 32'd1);
    end while (!done && n < 20);
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(n), 32'(lat));
    er = sb_res.pop_front();
    ee = sb_err.pop_front();
    check("result", 32'(result), 32'(er));
    check("err", 32'(err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("held_start_no_done", 32'(done), 32'd0);
    end
    start = 1'b0;
    for (int i = 0; i < ((hold == 0) ? 2 : 1); i++) begin
      @(posedge clk);
      #1;
      check("idle_no_done", 32'(done), 32'd0);
      check("idle_no_err", 32'(err), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    check("result_retained", 32'(result), 32'(er));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ro;
    reset = 1'b1;
    start = 1'b0;
    A     = 8'h00;
    B     = 8'h00;
    op    = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    reset = 1'b0;

    // Directed cases; first one starts on the very first cycle out of reset
    run_cmd(3'b001, 8'hFF, 8'h01, 1, 0);
    run_cmd(3'b100, 8'hFF, 8'hFF, 3, 0);
    run_cmd(3'b101, 8'h01, 8'h02, 1, 0);
    run_cmd(3'b110, 8'hF0, 8'h0F, 1, 0);
    run_cmd(3'b011, 8'hAA, 8'hFF, 1, 0);
    run_cmd(3'b010, 8'hAA, 8'h0F, 1, 0);
    run_cmd(3'b111, 8'h12, 8'h34, 1, 0);

    op    = 3'b000;
    A     = 8'h55;
    B     = 8'h66;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("nop_no_done", 32'(done), 32'd0);
      check("nop_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;
    @(posedge clk);
    #1;

    run_cmd(3'b001, 8'h03, 8'h04, 1, 4);
    run_cmd(3'b001, 8'h01, 8'h01, 1, 0);

    // Reset lands in the second cycle of a multiply
    op    = 3'b100;
    A     = 8'h10;
    B     = 8'h10;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("mul_busy_c1", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", 32'(result), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_mid_no_done", 32'(done), 32'd0);
    end
    run_cmd(3'b100, 8'h02, 8'h03, 3, 0);

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(1, 7));
      run_cmd(ro, 8'($urandom), 8'($urandom), (ro == 3'b100) ? 3 : 1, $urandom_range(0, 2));
    end

    check("scoreboard_empty", 32'(sb_res.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
